// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side drain engine for the synchronous FIFO.
// Pops words through read_enable/empty (data arrives one cycle after the pop),
// parks them in a small circular buffer and presents them on a valid/ready
// stream with no loss under backpressure.
// Optional feature macro: READER_LAST_EN adds m_last, asserted on the final
// word of every PKT_LEN-word packet.
module fifo_stream_reader #(
  parameter int DATA_W    = 6,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16,
  parameter int PKT_LEN   = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_enable,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef READER_LAST_EN
  output logic              m_last,
`endif
  output logic [CNT_W-1:0]  word_count,
  output logic              busy
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  // Reject out-of-range configurations at elaboration time.
  if (BUF_DEPTH < 2 || BUF_DEPTH > 8 || PKT_LEN < 2) begin : gParamCheck
    $error("fifo_stream_reader: illegal BUF_DEPTH or PKT_LEN");
  end

  logic [DATA_W-1:0] bufMem_q [BUF_DEPTH];
  logic [DATA_W-1:0] bufMem_d [BUF_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  wordCount_q, wordCount_d;
  logic              popReq;
  logic              xfer;
`ifdef READER_LAST_EN
  logic [CNT_W-1:0]  pktCnt_q, pktCnt_d;
  logic              lastBeat;
`endif

  // Circular pointer increment with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop only when the buffer can absorb every word already promised to it;
  // the reset term keeps the request low while arst_n is held.
  always_comb begin
    popReq = arst_n && !fifo_empty &&
             (({1'b0, occ_q} + (OCC_W+1)'(inflight_q)) < (OCC_W+1)'(BUF_DEPTH));
    xfer   = (occ_q != '0) && m_ready;
  end

  // Next-state: capture the word popped last cycle, retire the head on a transfer.
  always_comb begin
    bufMem_d    = bufMem_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    occ_d       = occ_q;
    wordCount_d = wordCount_q;
    inflight_d  = popReq;
    if (inflight_q) begin
      bufMem_d[wrPtr_q] = fifo_data;
      wrPtr_d           = nextPtr(wrPtr_q);
    end
    if (xfer) begin
      rdPtr_d     = nextPtr(rdPtr_q);
      wordCount_d = wordCount_q + 1'b1;
    end
    if (inflight_q && !xfer) begin
      occ_d = occ_q + 1'b1;
    end else if (!inflight_q && xfer) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // State registers; the asynchronous reset drops any word still in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        bufMem_q[i] <= '0;
      end
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      wordCount_q <= '0;
    end else begin
      bufMem_q    <= bufMem_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      wordCount_q <= wordCount_d;
    end
  end

`ifdef READER_LAST_EN
  // Packet position: the last beat of each packet wraps the counter to zero.
  always_comb begin
    lastBeat = (pktCnt_q == CNT_W'(PKT_LEN - 1));
    pktCnt_d = pktCnt_q;
    if (xfer) begin
      pktCnt_d = lastBeat ? '0 : pktCnt_q + 1'b1;
    end
  end

  // Packet counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pktCnt_q <= '0;
    end else begin
      pktCnt_q <= pktCnt_d;
    end
  end

  assign m_last = m_valid && lastBeat;
`endif

  assign fifo_read_enable = popReq;
  assign m_valid          = (occ_q != '0);
  assign m_data           = bufMem_q[rdPtr_q];
  assign word_count       = wordCount_q;
  assign busy             = inflight_q || (occ_q != '0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized bench for fifo_stream_reader.
// The bench plays the FIFO (a queue that answers pops one cycle later) and
// keeps a transaction-level model: words must leave in the order they were
// written, the buffer fill follows pops-minus-transfers, and the pop request
// follows the occupancy-plus-inflight limit. With READER_LAST_EN defined,
// m_last is checked against the beat number within each packet.
module tb_fifo_stream_reader;

  localparam int DATA_W    = 6;
  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 8;
  localparam int PKT_LEN   = 4;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read_enable;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
`ifdef READER_LAST_EN
  logic              m_last;
`endif

  fifo_stream_reader #(
    .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_read_enable(fifo_read_enable),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
`ifdef READER_LAST_EN
    .m_last(m_last),
`endif
    .word_count(word_count),
    .busy(busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic [DATA_W-1:0] fifoQ[$];
  logic [DATA_W-1:0] goldQ[$];
  int mOcc, mInflight, mXfers;
  int cycleIdx, popCount, firstValidCyc, firstXferCyc, lastXferCyc, actXfers;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushWord(input logic [DATA_W-1:0] w);
    fifoQ.push_back(w);
    goldQ.push_back(w);
  endtask

  task automatic clearModel();
    fifoQ.delete();
    goldQ.delete();
    mOcc = 0; mInflight = 0; mXfers = 0;
    cycleIdx = 0; popCount = 0; actXfers = 0;
    firstValidCyc = -1; firstXferCyc = -1; lastXferCyc = -1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic applyStimulus(input bit rdy);
    bit expPop, expValid, expXfer, actPop;
    m_ready    = rdy;
    fifo_empty = (fifoQ.size() == 0);
    #1;
    expPop   = !fifo_empty && (mOcc + mInflight < BUF_DEPTH);
    expValid = (mOcc != 0);
    checkOutput("readEnable", 32'(fifo_read_enable), 32'(expPop));
    checkOutput("valid", 32'(m_valid), 32'(expValid));
    checkOutput("busy", 32'(busy), 32'((mInflight != 0) || (mOcc != 0)));
    checkOutput("wordCount", 32'(word_count), 32'(mXfers % (1 << CNT_W)));
    if (expValid && goldQ.size() > 0) begin
      checkOutput("data", 32'(m_data), 32'(goldQ[0]));
    end
`ifdef READER_LAST_EN
    checkOutput("last", 32'(m_last), 32'(expValid && (mXfers % PKT_LEN == PKT_LEN - 1)));
`endif
    if (m_valid && firstValidCyc < 0) firstValidCyc = cycleIdx;
    if (m_valid && m_ready) begin
      if (firstXferCyc < 0) firstXferCyc = cycleIdx;
      lastXferCyc = cycleIdx;
      actXfers++;
    end
    expXfer = expValid && rdy;
    actPop  = fifo_read_enable;
    @(posedge clk);
    #1;
    mOcc      = mOcc + mInflight - int'(expXfer);
    mInflight = int'(expPop);
    if (expXfer) begin
      mXfers++;
      if (goldQ.size() > 0) void'(goldQ.pop_front());
    end
    if (actPop && fifoQ.size() > 0) begin
      fifo_data = fifoQ.pop_front();
      popCount++;
    end else begin
      fifo_data = DATA_W'($urandom);
    end
    cycleIdx++;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_readEnable"}, 32'(fifo_read_enable), 32'd0);
    checkOutput({tag, "_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_wordCount"}, 32'(word_count), 32'd0);
    checkOutput({tag, "_data"}, 32'(m_data), 32'd0);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    int pushed;
    int guard;
    arst_n     = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    clearModel();
    #3;
    checkResetState("initReset");

    // Streaming: eight preloaded words, consumer always ready.
    for (int i = 1; i <= 8; i++) pushWord(DATA_W'(i));
    releaseReset();
    guard = 0;
    while (actXfers < 8 && guard < 50) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkOutput("streamLatency", 32'(firstValidCyc), 32'd2);
    checkOutput("streamBeats", 32'(actXfers), 32'd8);
    checkOutput("streamNoGap", 32'(lastXferCyc - firstXferCyc), 32'd7);
    checkOutput("streamCount", 32'(word_count), 32'd8);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);

    // Asynchronous reset while the buffer holds stalled words.
    for (int i = 0; i < 5; i++) pushWord(DATA_W'($urandom));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);
    checkOutput("preResetValid", 32'(m_valid), 32'd1);
    fifo_empty = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    checkResetState("midReset");
    clearModel();
    fifo_empty = 1'b1;

    // Backpressure: five words, consumer stalled for ten cycles.
    for (int i = 0; i < 5; i++) pushWord(DATA_W'(8'h0A + i));
    releaseReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0);
    checkOutput("bpPops", 32'(popCount), 32'(BUF_DEPTH < 5 ? BUF_DEPTH : 5));
    checkOutput("bpHoldData", 32'(m_data), 32'h0A);
    guard = 0;
    while (goldQ.size() > 0 && guard < 40) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkOutput("bpDrained", 32'(goldQ.size()), 32'd0);
    checkOutput("bpCount", 32'(word_count), 32'd5);
    checkOutput("bpTotalPops", 32'(popCount), 32'd5);

    // Random traffic and random ready; count wraps several times.
    arst_n = 1'b0;
    #1;
    clearModel();
    releaseReset();
    pushed = 0;
    guard  = 0;
    while ((pushed < 1000 || goldQ.size() > 0) && guard < 30000) begin
      if (pushed < 1000 && fifoQ.size() < 16 && ($urandom % 4 != 0)) begin
        pushWord(DATA_W'($urandom));
        pushed++;
      end
      applyStimulus(($urandom % 3) != 0);
      guard++;
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    checkOutput("randDrained", 32'(goldQ.size()), 32'd0);
    checkOutput("randBeats", 32'(actXfers), 32'd1000);
    checkOutput("randCount", 32'(word_count), 32'(1000 % (1 << CNT_W)));
    checkOutput("randIdle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
